// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Purpose:
//   Sequential packed-BCD to binary converter that uses the reverse
//   double-dabble algorithm. Each clock in CONV shifts the working register
//   right by one bit. Any BCD digit of the shifted value that is >= 8 then
//   has 3 subtracted from it. After BIN_W shifts, the binary field holds the
//   result. Requests that contain a non-decimal digit are rejected at once
//   and flagged with err. This block converts keypad and time-set entries
//   back into binary for the clock counters.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, sampled only when busy=0
//   bcd_in   in   packed BCD, digit 0 in bits [3:0]
//   busy     out  high while a conversion is shifting (CONV state)
//   done     out  one-cycle pulse when bin_out and err are updated
//   err      out  1 = last request contained a digit > 9
//   bin_out  out  binary result, held until the next done
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,  // ceil(log2(10^DIGITS))
  parameter int CNT_W  = 4    // 2^CNT_W > BIN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int R_W   = BCD_W + BIN_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [R_W-1:0]     r_q, r_d;          // {bcd field, binary field}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;

  logic               bad_digit;
  logic [R_W-1:0]     r_shift;
  logic [R_W-1:0]     r_corr;

  // Input validation: flag any digit above 9 using a full 4-bit compare.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift right, then correct the digits.
  // The top digit always receives a 0 in its MSB, and subtraction happens
  // only on values >= 8, so the subtract-3 can never wrap.
  always_comb begin
    r_shift = r_q >> 1;
    r_corr  = r_shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_shift[BIN_W + 4*i +: 4] >= 4'd8) begin
        r_corr[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request just as IDLE does, which lets
        // conversions run back to back.
        state_d = IDLE;
        if (start) begin
          if (bad_digit) begin
            state_d   = DONE;
            err_d     = 1'b1;
            bin_out_d = '0;
          end else begin
            state_d = CONV;
            r_d     = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
          end
        end
      end

      CONV: begin
        r_d   = r_corr;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // This is the last shift. The binary field of the corrected value
          // is already final, because correction only touches BCD digits.
          state_d   = DONE;
          bin_out_d = r_corr[BIN_W-1:0];
          err_d     = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q == CONV);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//
// Directed bench for bcd_to_bin_seq. Expected results are hand-computed
// decimal values. Latency is counted as the number of rising edges from the
// edge that samples start to the edge that raises done: 14 for a valid
// request and 0 for a rejected one, where done is visible right after the
// sampling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int CNT_W  = 4;
  localparam int BUDGET = 40;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [15:0]        bcd_in;
  logic               busy;
  logic               done;
  logic               err;
  logic [BIN_W-1:0]   bin_out;

  int n_checks = 0;
  int n_err    = 0;

  bcd_to_bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, obs, obs, exp, exp);
    end
  endtask

  // Called at the negedge right after the start-sampling edge. Waits for
  // done, counts the edges that elapse and the cycles with busy high.
  task automatic wait_done(output int lat, output int busy_cnt,
                           output bit seen);
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (lat < BUDGET) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issues one request, checks the result and the single-cycle done pulse,
  // and checks that the result holds once done drops.
  task automatic run_conv(input string tag, input logic [15:0] v,
                          input int exp_bin, input logic exp_err,
                          input int exp_lat);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'hFFFF;  // the value must already be captured
    wait_done(lat, bcnt, seen);
    check({tag, ".seen"}, 32'(seen), 32'd1);
    check({tag, ".lat"},  32'(lat),  32'(exp_lat));
    check({tag, ".busy"}, 32'(bcnt), 32'(exp_lat));
    check({tag, ".bin"},  32'(bin_out), 32'(exp_bin));
    check({tag, ".err"},  32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
    check({tag, ".hold"},  32'(bin_out), 32'(exp_bin));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bcnt;
    bit seen;
    int saw_done;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err",  32'(err),  32'd0);
    check("rst.bin",  32'(bin_out), 32'd0);
    rst_n = 1'b1;

    // Valid conversions
    run_conv("v0000", 16'h0000, 0,    1'b0, 14);
    run_conv("v1234", 16'h1234, 1234, 1'b0, 14);
    run_conv("v9999", 16'h9999, 9999, 1'b0, 14);
    run_conv("v0001", 16'h0001, 1,    1'b0, 14);
    run_conv("v0990", 16'h0990, 990,  1'b0, 14);

    // Invalid digit is rejected without a conversion
    run_conv("i12A4", 16'h12A4, 0,    1'b1, 0);
    run_conv("v0042", 16'h0042, 42,   1'b0, 14);
    run_conv("iF000", 16'hF000, 0,    1'b1, 0);
    run_conv("v8000", 16'h8000, 8000, 1'b0, 14);

    // A start during CONV is ignored. A start in the done cycle is accepted.
    @(negedge clk);
    bcd_in = 16'h0500;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    bcd_in = 16'h0009;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(lat, bcnt, seen);
    check("b2b1.seen", 32'(seen), 32'd1);
    check("b2b1.lat",  32'(lat + 4), 32'd14);
    check("b2b1.bin",  32'(bin_out), 32'd500);
    check("b2b1.err",  32'(err), 32'd0);
    bcd_in = 16'h0077;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("b2b2.busy_now", 32'(busy), 32'd1);
    wait_done(lat, bcnt, seen);
    check("b2b2.seen", 32'(seen), 32'd1);
    check("b2b2.lat",  32'(lat), 32'd14);
    check("b2b2.bin",  32'(bin_out), 32'd77);

    // Reset after the sixth shift aborts the conversion with no done pulse
    @(negedge clk);
    bcd_in = 16'h4321;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (6) @(negedge clk);
    check("abort.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.err",  32'(err),  32'd0);
    check("abort.bin",  32'(bin_out), 32'd0);
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("abort.nodone", 32'(saw_done), 32'd0);
    run_conv("v0010", 16'h0010, 10, 1'b0, 14);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
